// File: rtl/hwpe_ctrl_uloop_seq.sv
// Job-level sequencer behind the HWPE micro-loop engine: requests one uloop
// iteration at a time and buffers the resulting absolute tile addresses.

package hwpe_ctrl_uloop_seq_pkg;
  localparam int unsigned ULOOP_MAX_NB_REG   = 8;
  localparam int unsigned ULOOP_MAX_NB_LOOPS = 6;

  typedef struct packed {
    logic enable;
    logic clear;
    logic ready;
  } ctrl_uloop_t;

  typedef struct packed {
    logic [ULOOP_MAX_NB_REG-1:0][31:0]   offs;
    logic [ULOOP_MAX_NB_LOOPS-1:0][15:0] idx;
    logic                                done;
    logic                                valid;
    logic                                ready;
  } flags_uloop_t;
endpackage

module hwpe_ctrl_uloop_seq
  import hwpe_ctrl_uloop_seq_pkg::*;
#(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [REG_WIDTH-1:0]                 base_addr_i,
  output ctrl_uloop_t                          uloop_ctrl_o,
  input  flags_uloop_t                         uloop_flags_i,
  output logic                                 tile_valid_o,
  input  logic                                 tile_ready_i,
  output logic [NB_REG-1:0][REG_WIDTH-1:0]     tile_addr_o,
  output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   tile_idx_o,
  output logic                                 tile_last_o,
  output logic [CNT_WIDTH-1:0]                 tile_count_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef logic [NB_REG-1:0][REG_WIDTH-1:0]   addr_vec_t;
  typedef logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_vec_t;

  logic [2:0]           state_q, state_d;
  logic [REG_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       occ_q, occ_d;

  addr_vec_t            fifo_addr_q [FIFO_DEPTH];
  idx_vec_t             fifo_idx_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;

  addr_vec_t push_addr;
  idx_vec_t  push_idx;
  logic      full, empty, push, pop;
  logic      unused_flags;

  // flag fields beyond the forwarded lanes are intentionally not consumed
  assign unused_flags = ^uloop_flags_i;

  for (genvar gi = 0; gi < NB_REG; gi++) begin : gen_addr
    assign push_addr[gi] = base_q + uloop_flags_i.offs[gi][REG_WIDTH-1:0];
  end
  for (genvar gi = 0; gi < NB_LOOPS; gi++) begin : gen_idx
    assign push_idx[gi] = uloop_flags_i.idx[gi][CNT_WIDTH-1:0];
  end

  assign full  = (occ_q == DEPTH);
  assign empty = (occ_q == '0);
  assign push  = (state_q == ST_WAIT) && uloop_flags_i.valid && !clear_i;
  assign pop   = !empty && tile_ready_i && !clear_i;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    err_d        = err_q;
    done_d       = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    uloop_ctrl_o = '0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLR;
          base_d  = base_addr_i;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_CLR: begin
        uloop_ctrl_o.clear = 1'b1;
        state_d            = ST_RUN;
      end
      ST_RUN: begin
        if (!full) begin
          uloop_ctrl_o.enable = 1'b1;
          state_d             = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (uloop_flags_i.valid) state_d = uloop_flags_i.done ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        // finish in the same cycle the last pop empties the buffer
        if (occ_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    uloop_ctrl_o.ready = ((state_q == ST_RUN) || (state_q == ST_WAIT)) && !full;
    if (uloop_flags_i.valid && (state_q != ST_WAIT)) err_d = 1'b1;

    if (clear_i) begin
      state_d      = ST_IDLE;
      count_d      = '0;
      err_d        = 1'b0;
      done_d       = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      uloop_ctrl_o = '0;
      uloop_ctrl_o.clear = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= push_addr;
        fifo_idx_q[wr_ptr_q]  <= push_idx;
        fifo_last_q[wr_ptr_q] <= uloop_flags_i.done;
      end
    end
  end

  assign tile_valid_o = !empty;
  assign tile_addr_o  = fifo_addr_q[rd_ptr_q];
  assign tile_idx_o   = fifo_idx_q[rd_ptr_q];
  assign tile_last_o  = fifo_last_q[rd_ptr_q];
  assign tile_count_o = count_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: doc/hwpe_ctrl_uloop_seq.md
# hwpe_ctrl_uloop_seq

Job-level sequencer that sits directly downstream of the HWPE micro-loop engine. The engine runs in its non-shadowed configuration. On a start pulse the sequencer clears the engine, then requests one iteration at a time through `ctrl_uloop_t`. It captures each returned `flags_uloop_t` (offsets, indices, done) and turns it into absolute streamer base addresses. Those addresses are pushed through a small FIFO to the streamer controller over a valid/ready handshake, with backpressure throttling the engine.

## Interface
- NB_REG, 4: number of uloop offset registers forwarded.
- REG_WIDTH, 32: offset/address width.
- NB_LOOPS, 6: number of loop indices forwarded.
- CNT_WIDTH, 16: loop index and tile counter width.
- FIFO_DEPTH, 2: tile buffer depth; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  job start pulse; ignored unless state is IDLE.
- base_addr_i  in  REG_WIDTH  job base address; sampled on accepted start_i.
- uloop_ctrl_o  out  ctrl_uloop_t  fields enable, clear, ready driven; all other fields 0.
- uloop_flags_i  in  flags_uloop_t  fields valid, done, offs, idx used.
- tile_valid_o  out  1  FIFO head valid.
- tile_ready_i  in  1  consumer accept.
- tile_addr_o  out  NB_REG×REG_WIDTH  base + offs[i], per register.
- tile_idx_o  out  NB_LOOPS×CNT_WIDTH  loop indices of the tile.
- tile_last_o  out  1  tile was produced with done=1.
- tile_count_o  out  CNT_WIDTH  tiles popped since last start.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse when the job completes.
- err_o  out  1  sticky protocol error.

## Operation
- FSM states and transitions:
  - IDLE: start_i goes to CLR. On entry, latch base_addr_i, zero tile_count_o, clear err_o.
  - CLR: drive uloop_ctrl_o.clear=1 for exactly 1 cycle, then go to RUN.
  - RUN: if the FIFO is not full, drive enable=1 for 1 cycle and go to WAIT. Otherwise stay in RUN with enable=0.
  - WAIT: wait for uloop_flags_i.valid. On valid, push {base+offs[i], idx[i], last=done}. If done=1 go to DRAIN, else go to RUN.
  - DRAIN: when the FIFO is empty, pulse done_o and go to IDLE.
- At most one iteration is outstanding. Enable is only issued with a free FIFO slot, so a push can never overflow.
- uloop_ctrl_o.ready = 1 in RUN/WAIT when the FIFO is not full; 0 otherwise.
- Address arithmetic: each lane is REG_WIDTH-bit unsigned modulo 2^REG_WIDTH, with carry discarded. Only offs[0..NB_REG-1] and idx[0..NB_LOOPS-1] are used.
- FIFO is register-based with no bypass. Pop happens when tile_valid_o & tile_ready_i. Push and pop in the same cycle are both honoured at any occupancy below full.
- tile_count_o increments on each pop and wraps at 2^CNT_WIDTH.
- Error: uloop_flags_i.valid seen in any state other than WAIT sets err_o. The flags are ignored and the FSM is unaffected. err_o holds until the next accepted start_i, clear_i, or reset.
- clear_i takes priority over all other inputs:
  - Same cycle: uloop_ctrl_o.clear=1 (combinational), enable=0.
  - Next cycle: state=IDLE, FIFO empty, counters and err_o zero, no done_o.
- Reset values: all outputs 0, state IDLE, FIFO empty.

## Timing
- start_i at cycle 0 gives clear=1 at cycle 1 and enable=1 at cycle 2. Enable is a single-cycle pulse per iteration.
- flags valid at cycle k gives tile_valid_o=1 at cycle k+1 (FIFO previously empty). It also gives the next enable at cycle k+1, provided the FIFO is not full after the push.
- Last tile popped at cycle p (FIFO then empty) gives done_o=1 at cycle p+1 and busy_o=0 at cycle p+1.
- tile_* outputs are registered and stable while tile_valid_o=1 and tile_ready_i=0.
- Job with only a done response (done and valid together on the first iteration): one tile is emitted with tile_last_o=1.

## Test plan
- Basic job, base=0x1000, engine returns 3 iterations with offs[0]=0x0, 0x40, 0x80 (done on 3rd), tile_ready_i=1 → tile_addr_o[0]=0x1000, 0x1040, 0x1080; tile_last_o only on the 3rd; tile_count_o=3; one done_o pulse.
- Backpressure: tile_ready_i=0 with FIFO_DEPTH=2 → exactly 2 enables issued, then enable held 0. Raising ready gives one enable per freed slot; no tile lost or duplicated.
- Wrap: base=0xFFFF_FFF0, offs[1]=0x20 → tile_addr_o[1]=0x0000_0010.
- clear_i asserted in WAIT with 1 tile buffered → uloop_ctrl_o.clear=1 same cycle; next cycle tile_valid_o=0, busy_o=0; later flags valid → err_o=1.
- Spurious valid in IDLE → err_o=1, no push. A subsequent start_i clears err_o; start_i while busy is ignored, base unchanged.
- Async reset mid-DRAIN → all outputs 0 immediately; no done_o after release.
